pwm_ramp_ctrl: RTL and testbench

//   Sequencer in front of a PWM generator. Accepts target duty commands over a valid/ready

---
 rtl/pwm_ctrl_pkg.sv | 20 ++
 rtl/pwm_ramp_ctrl_timer.sv | 55 +++++
 rtl/pwm_ramp_ctrl.sv | 142 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: FSM encodings and
// helpers for sizing the period/hold counters.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_STEADY = 2'd2
  } pwm_state_e;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter widths for the default configuration (PERIOD=10, HOLD_PERIODS=4).
  localparam int DEF_PERIOD_W = cnt_w(10);
  localparam int DEF_HOLD_W   = cnt_w(4);

endpackage

// File: rtl/pwm_ramp_ctrl_timer.sv
// Period and hold counters. period_tick marks the last cycle of each PWM
// period; step_tick marks the period_tick on which the hold count is on its
// last value. Both ticks are registered: they are computed from the next
// counter values so they line up with the counters they describe.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int PERIOD       = 10,
  parameter int HOLD_PERIODS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_all,
  input  logic clr_hold,
  output logic period_tick,
  output logic step_tick
);

  localparam int PW = cnt_w(PERIOD);
  localparam int HW = cnt_w(HOLD_PERIODS);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_PERIODS - 1);

  logic [PW-1:0] period_q, period_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          tick_d, step_d;

  // Next counter values and the ticks they will produce.
  always_comb begin
    period_d = period_q + PW'(1);
    if (clr_all || period_q == P_LAST) period_d = '0;
    tick_d = (period_d == P_LAST);

    hold_d = hold_q;
    if (clr_all || clr_hold)  hold_d = '0;
    else if (period_tick)     hold_d = (hold_q == H_LAST) ? '0 : hold_q + HW'(1);
    step_d = tick_d && (hold_d == H_LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q    <= '0;
      hold_q      <= '0;
      period_tick <= 1'b0;
      step_tick   <= 1'b0;
    end else begin
      period_q    <= period_d;
      hold_q      <= hold_d;
      period_tick <= tick_d;
      step_tick   <= step_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer in front of a PWM generator. Commands set a target duty;
// the duty output walks toward it by STEP once every HOLD_PERIODS periods,
// always changing on a period boundary.
//
// Handshake: a command is taken on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high in IDLE and STEADY unless abort
// is asserted, and cmd_target must be stable while cmd_valid is high.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W       = 4,
  parameter int PERIOD       = 10,
  parameter int HOLD_PERIODS = 4,
  parameter int STEP         = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_target,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              pwm_en,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic              period_tick,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] STEP_W   = DUTY_W'(STEP);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(STEP);

  pwm_state_e        state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d, duty_d, tgt_c, ramp_duty;
  logic [DUTY_W:0]   duty_x, tgt_x, up_x, diff_x;
  logic              up_dir, up_sat, dn_sat;
  logic              accept, done_d, clr_all, clr_hold, step_tick;

  assign cmd_ready = !abort && (state_q == ST_IDLE || state_q == ST_STEADY);
  assign accept    = cmd_valid && cmd_ready;
  assign tgt_c     = (cmd_target > PERIOD_V) ? PERIOD_V : cmd_target;
  assign dbg_state = state_q;

  // Saturating step toward target, done one bit wider so duty+STEP never wraps.
  assign duty_x    = {1'b0, duty_q_w()};
  assign tgt_x     = {1'b0, target_q};
  assign up_x      = duty_x + STEP_X;
  assign diff_x    = duty_x - tgt_x;
  assign up_dir    = (duty_x < tgt_x);
  assign up_sat    = (up_x >= tgt_x);
  assign dn_sat    = (diff_x <= STEP_X);
  assign ramp_duty = up_dir ? (up_sat ? target_q : up_x[DUTY_W-1:0])
                            : (dn_sat ? target_q : pwm_duty - STEP_W);

  function automatic logic [DUTY_W-1:0] duty_q_w();
    return pwm_duty;
  endfunction

  pwm_period_timer #(
    .PERIOD      (PERIOD),
    .HOLD_PERIODS(HOLD_PERIODS)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_all    (clr_all),
    .clr_hold   (clr_hold),
    .period_tick(period_tick),
    .step_tick  (step_tick)
  );

  // Next state, target, duty and done pulse; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    duty_d   = pwm_duty;
    done_d   = 1'b0;
    clr_hold = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      target_d = '0;
      duty_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (accept) begin
            target_d = tgt_c;
            if (tgt_c != '0) state_d = ST_RAMP;
            else             done_d  = 1'b1;
          end
        end
        ST_RAMP: begin
          if (step_tick) begin
            duty_d = ramp_duty;
            if (ramp_duty == target_q) begin
              done_d  = 1'b1;
              state_d = (target_q != '0) ? ST_STEADY : ST_IDLE;
            end
          end
        end
        ST_STEADY: begin
          if (accept) begin
            target_d = tgt_c;
            if (tgt_c != pwm_duty) begin
              state_d  = ST_RAMP;
              clr_hold = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
    // Counters sit at zero in IDLE and restart from zero on leaving it.
    clr_all = abort || (state_q == ST_IDLE) || (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      pwm_duty <= '0;
      pwm_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pwm_duty <= duty_d;
      pwm_en   <= (state_d != ST_IDLE);
      busy     <= (state_d == ST_RAMP);
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl (DUTY_W=4, PERIOD=10, HOLD_PERIODS=2,
// STEP=2). Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_ramp_ctrl;

  localparam int DUTY_W = 4;
  localparam int PERIOD = 10;
  localparam int HOLD   = 2;
  localparam int STEP   = 2;

  logic              clk;
  logic              reset_n;
  logic              cmd_valid;
  logic [DUTY_W-1:0] cmd_target;
  logic              cmd_ready;
  logic              abort;
  logic              pwm_en;
  logic [DUTY_W-1:0] pwm_duty;
  logic              period_tick;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  pwm_ramp_ctrl #(
    .DUTY_W(DUTY_W), .PERIOD(PERIOD), .HOLD_PERIODS(HOLD), .STEP(STEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_ready(cmd_ready), .abort(abort), .pwm_en(pwm_en), .pwm_duty(pwm_duty),
    .period_tick(period_tick), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DUTY_W-1:0] exp_q[$];

  typedef struct {
    int target;
    int exp_final;
    int exp_steps;
    bit from_idle;
  } row_t;
  row_t rows[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_tgt(input int t);
    return (t > PERIOD) ? PERIOD : t;
  endfunction

  // Scoreboard model: expected duty after each ramp step.
  task automatic push_expected(input int cur, input int tgt);
    int t, d;
    t = clamp_tgt(tgt);
    d = cur;
    while (d != t) begin
      if (d < t) d = (d + STEP >= t) ? t : d + STEP;
      else       d = (d - t <= STEP) ? t : d - STEP;
      exp_q.push_back(DUTY_W'(d));
    end
  endtask

  // Driver + monitor for one command: accept, then follow the ramp to done.
  task automatic run_row(input row_t r, input int cur);
    int c, prev, steps, dones, last_chg, done_cyc, ready_bad, over;
    bit finished;
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_target = DUTY_W'(r.target);
    push_expected(cur, r.target);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("en_after_accept", pwm_en, 1);
    prev = cur; steps = 0; dones = 0; last_chg = -1; done_cyc = -10;
    ready_bad = 0; over = 0; finished = 0;
    c = 1;
    while (c <= 400 && !finished) begin
      if (c > 1) @(negedge clk);
      if (pwm_duty > PERIOD) over++;
      if (busy && cmd_ready) ready_bad++;
      if (done) begin
        dones++;
        done_cyc = c;
        chk("duty_at_done", pwm_duty, clamp_tgt(r.target));
      end
      if (int'(pwm_duty) != prev) begin
        steps++;
        if (exp_q.size() == 0) chk("unexpected_step", pwm_duty, prev);
        else chk("duty_step", pwm_duty, exp_q.pop_front());
        if (last_chg >= 0)    chk("step_spacing", c - last_chg, PERIOD * HOLD);
        else if (r.from_idle) chk("first_step_latency", c, PERIOD * HOLD + 1);
        last_chg = c;
        prev = pwm_duty;
      end
      if (dones > 0 && c == done_cyc + 1) finished = 1;
      c++;
    end
    chk("ramp_finished", finished, 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("step_count", steps, r.exp_steps);
    chk("done_count", dones, 1);
    chk("final_duty", pwm_duty, r.exp_final);
    chk("busy_after_done", busy, 0);
    chk("ready_low_in_ramp", ready_bad, 0);
    chk("no_overshoot", over, 0);
    chk("state_after_done", dbg_state, (r.target == 0) ? 0 : 2);
    chk("en_after_done", pwm_en, (r.target == 0) ? 0 : 1);
    if (r.from_idle && r.exp_steps == 3) chk("done_cycle", done_cyc, 3 * PERIOD * HOLD + 1);
  endtask

  initial begin
    int cur, ticks;
    rows[0] = '{target: 6,  exp_final: 6,  exp_steps: 3, from_idle: 1};
    rows[1] = '{target: 1,  exp_final: 1,  exp_steps: 3, from_idle: 0};
    rows[2] = '{target: 15, exp_final: 10, exp_steps: 5, from_idle: 0};
    rows[3] = '{target: 4,  exp_final: 4,  exp_steps: 3, from_idle: 0};
    rows[4] = '{target: 0,  exp_final: 0,  exp_steps: 2, from_idle: 0};
    rows[5] = '{target: 2,  exp_final: 2,  exp_steps: 1, from_idle: 1};

    cmd_valid = 1'b0; cmd_target = '0; abort = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_pwm_duty", pwm_duty, 0);
    chk("rst_period_tick", period_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;

    // Reset asserted in the middle of a ramp
    @(negedge clk);
    cmd_valid = 1'b1; cmd_target = 4'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat ($urandom_range(29, 35)) @(negedge clk);
    chk("mid_ramp_busy", busy, 1);
    chk("mid_ramp_duty", pwm_duty, 2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_en", pwm_en, 0);
    chk("async_rst_duty", pwm_duty, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("held_rst_en", pwm_en, 0);
    end
    reset_n = 1'b1;

    // Table of chained commands
    cur = 0;
    for (int i = 0; i < 5; i++) begin
      run_row(rows[i], cur);
      cur = rows[i].exp_final;
      if (rows[i].target == 15) begin
        ticks = 0;
        repeat (5 * PERIOD) begin
          @(negedge clk);
          if (period_tick) ticks++;
        end
        chk("steady_tick_count", ticks, 5);
        chk("steady_duty_held", pwm_duty, 10);
      end
    end

    // Zero target while idle: done next cycle, PWM stays off
    @(negedge clk);
    cmd_valid = 1'b1; cmd_target = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("idle_zero_done", done, 1);
    chk("idle_zero_en", pwm_en, 0);
    @(negedge clk);
    chk("idle_zero_done_pulse", done, 0);
    chk("idle_zero_en_later", pwm_en, 0);

    // Abort colliding with a command in STEADY
    run_row(rows[5], 0);
    repeat ($urandom_range(1, 9)) @(negedge clk);
    cmd_valid = 1'b1; cmd_target = 4'd7; abort = 1'b1;
    #1;
    chk("abort_ready_low", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    chk("abort_en", pwm_en, 0);
    chk("abort_duty", pwm_duty, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_no_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (2 * PERIOD * HOLD) begin
      @(negedge clk);
      if (done || pwm_en) chk("abort_stays_idle", {done, pwm_en}, 0);
    end
    chk("abort_final_state", dbg_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
